// File: rtl/game_board.sv
// game_board: 3x3 tic-tac-toe board with write validation and an
// eight-cycle sequential win scan after each accepted move.
module game_board (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       we,
  input  logic [3:0] addr,
  input  logic [1:0] cellState,
  input  logic [3:0] rdAddr,
  output logic [1:0] rdData,
  output logic       ack,
  output logic       err,
  output logic       busy,
  output logic       gameIsDone,
  output logic [1:0] winner,
  output logic [2:0] winLine
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } stateT;

  stateT      state;
  stateT      nextState;
  logic [1:0] board [9];
  logic [2:0] lineIdx;
  logic       matchFound;
  logic       targetEmpty;
  logic       writeOk;
  logic       accept;
  logic       reject;
  logic [3:0] idxA;
  logic [3:0] idxB;
  logic [3:0] idxC;
  logic [1:0] cellA;
  logic [1:0] cellB;
  logic [1:0] cellC;
  logic       lineMatch;
  logic       boardFull;
  logic       lastLine;

  // Decide whether the requested write is legal: valid address, empty target, real symbol.
  always_comb begin
    targetEmpty = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (addr == i[3:0]) begin
        targetEmpty = (board[i] == 2'b00);
      end
    end
    writeOk = (addr <= 4'd8) && targetEmpty && cellState[1];
    accept  = (state == IDLE) && we && !clear && writeOk;
    reject  = we && !clear && !accept;
  end

  // Map the current scan index to the three cells of that line.
  always_comb begin
    idxA = 4'd0;
    idxB = 4'd1;
    idxC = 4'd2;
    case (lineIdx)
      3'd0: begin idxA = 4'd0; idxB = 4'd1; idxC = 4'd2; end
      3'd1: begin idxA = 4'd3; idxB = 4'd4; idxC = 4'd5; end
      3'd2: begin idxA = 4'd6; idxB = 4'd7; idxC = 4'd8; end
      3'd3: begin idxA = 4'd0; idxB = 4'd3; idxC = 4'd6; end
      3'd4: begin idxA = 4'd1; idxB = 4'd4; idxC = 4'd7; end
      3'd5: begin idxA = 4'd2; idxB = 4'd5; idxC = 4'd8; end
      3'd6: begin idxA = 4'd0; idxB = 4'd4; idxC = 4'd8; end
      3'd7: begin idxA = 4'd2; idxB = 4'd4; idxC = 4'd6; end
      default: begin idxA = 4'd0; idxB = 4'd1; idxC = 4'd2; end
    endcase
  end

  // Evaluate the selected line and whether every cell is occupied.
  always_comb begin
    cellA     = board[idxA];
    cellB     = board[idxB];
    cellC     = board[idxC];
    lineMatch = (cellA != 2'b00) && (cellA == cellB) && (cellB == cellC);
    lastLine  = (lineIdx == 3'd7);
    boardFull = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (board[i] == 2'b00) begin
        boardFull = 1'b0;
      end
    end
  end

  // Next-state logic; clear always returns to IDLE, the scan ends after line 7.
  always_comb begin
    nextState = state;
    if (clear) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            nextState = CHECK;
          end
        end
        CHECK: begin
          if (lastLine) begin
            if (matchFound || lineMatch || boardFull) begin
              nextState = DONE;
            end else begin
              nextState = IDLE;
            end
          end
        end
        DONE: begin
          nextState = DONE;
        end
        default: begin
          nextState = IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Board storage, scan bookkeeping, result latches and registered handshake/read outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 9; i++) begin
        board[i] <= 2'b00;
      end
      lineIdx    <= 3'd0;
      matchFound <= 1'b0;
      winner     <= 2'b00;
      winLine    <= 3'd0;
      ack        <= 1'b0;
      err        <= 1'b0;
      rdData     <= 2'b00;
    end else if (clear) begin
      for (int i = 0; i < 9; i++) begin
        board[i] <= 2'b00;
      end
      lineIdx    <= 3'd0;
      matchFound <= 1'b0;
      winner     <= 2'b00;
      winLine    <= 3'd0;
      ack        <= 1'b0;
      err        <= 1'b0;
      rdData     <= 2'b00;
    end else begin
      ack    <= accept;
      err    <= reject;
      rdData <= (rdAddr <= 4'd8) ? board[rdAddr] : 2'b00;
      for (int i = 0; i < 9; i++) begin
        if (accept && (addr == i[3:0])) begin
          board[i] <= cellState;
        end
      end
      if (accept) begin
        lineIdx    <= 3'd0;
        matchFound <= 1'b0;
        winner     <= 2'b00;
        winLine    <= 3'd0;
      end else if (state == CHECK) begin
        lineIdx <= lineIdx + 3'd1;
        if (lineMatch && !matchFound) begin
          matchFound <= 1'b1;
          winner     <= cellA;
          winLine    <= lineIdx;
        end
      end
    end
  end

  // Status outputs decoded directly from the state register.
  always_comb begin
    busy       = (state == CHECK);
    gameIsDone = (state == DONE);
  end

endmodule

// File: tb/tb_game_board.sv
// tb_game_board: scoreboard bench for game_board; stimulus pushes expected
// ack/err, game-end and sampled-value events, a monitor checks them mid-cycle.
module tb_game_board;

  localparam logic [1:0] SX = 2'b10;
  localparam logic [1:0] SO = 2'b11;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       we;
  logic [3:0] addr;
  logic [1:0] cellState;
  logic [3:0] rdAddr;
  logic [1:0] rdData;
  logic       ack;
  logic       err;
  logic       busy;
  logic       gameIsDone;
  logic [1:0] winner;
  logic [2:0] winLine;

  typedef struct {
    logic isAck;
    int   cycle;
  } respT;

  typedef struct {
    int         cycle;
    logic [1:0] win;
    logic [2:0] line;
  } doneT;

  typedef struct {
    int    cycle;
    int    sig;
    int    exp;
    string name;
  } probeT;

  respT  respQ[$];
  doneT  doneQ[$];
  probeT probeQ[$];
  probeT probeKeep[$];

  int   testsRun = 0;
  int   testsFailed = 0;
  int   cycleCnt = 0;
  logic prevDone = 1'b0;

  game_board dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .we        (we),
    .addr      (addr),
    .cellState (cellState),
    .rdAddr    (rdAddr),
    .rdData    (rdData),
    .ack       (ack),
    .err       (err),
    .busy      (busy),
    .gameIsDone(gameIsDone),
    .winner    (winner),
    .winLine   (winLine)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count rising edges so expectations can be tied to a specific cycle.
  always @(posedge clk) begin
    cycleCnt = cycleCnt + 1;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleCnt);
    end
  endtask

  function automatic int sigVal(input int s);
    case (s)
      0:       return int'(rdData);
      1:       return int'(busy);
      2:       return int'(gameIsDone);
      3:       return int'(winner);
      4:       return int'(winLine);
      5:       return int'(ack);
      6:       return int'(err);
      default: return -1;
    endcase
  endfunction

  // Monitor: match ack/err pulses, game-end events and sampled values against the queues.
  always @(negedge clk) begin
    respT r;
    doneT d;
    if (ack || err) begin
      checkOutput("ackErrExclusive", int'(ack && err), 0);
      if (respQ.size() == 0) begin
        checkOutput("unexpectedResp", int'({ack, err}), 0);
      end else begin
        r = respQ.pop_front();
        checkOutput("respKind", int'(ack), int'(r.isAck));
        checkOutput("respCycle", cycleCnt, r.cycle);
      end
    end
    if (respQ.size() > 0 && respQ[0].cycle < cycleCnt) begin
      r = respQ.pop_front();
      checkOutput("missingResp", cycleCnt, r.cycle);
    end

    if (gameIsDone && !prevDone) begin
      if (doneQ.size() == 0) begin
        checkOutput("unexpectedDone", int'(gameIsDone), 0);
      end else begin
        d = doneQ.pop_front();
        checkOutput("doneCycle", cycleCnt, d.cycle);
        checkOutput("doneWinner", int'(winner), int'(d.win));
        checkOutput("doneWinLine", int'(winLine), int'(d.line));
      end
    end
    if (doneQ.size() > 0 && doneQ[0].cycle < cycleCnt) begin
      d = doneQ.pop_front();
      checkOutput("missingDone", cycleCnt, d.cycle);
    end
    prevDone = gameIsDone;

    probeKeep = {};
    foreach (probeQ[i]) begin
      if (probeQ[i].cycle <= cycleCnt) begin
        checkOutput(probeQ[i].name, sigVal(probeQ[i].sig), probeQ[i].exp);
      end else begin
        probeKeep.push_back(probeQ[i]);
      end
    end
    probeQ = probeKeep;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input int sig, input int exp, input string name, input int delay);
    probeT p;
    p.cycle = cycleCnt + delay;
    p.sig   = sig;
    p.exp   = exp;
    p.name  = name;
    probeQ.push_back(p);
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [1:0] s, input logic expAck,
                               input logic expDone, input logic [1:0] expWin,
                               input logic [2:0] expLine);
    respT r;
    doneT d;
    addr      = a;
    cellState = s;
    we        = 1'b1;
    r.isAck   = expAck;
    r.cycle   = cycleCnt + 1;
    respQ.push_back(r);
    if (expDone) begin
      d.cycle = cycleCnt + 9;
      d.win   = expWin;
      d.line  = expLine;
      doneQ.push_back(d);
    end
    tick();
    we = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    if (busy) begin
      checkOutput("busyTimeout", int'(busy), 0);
    end
  endtask

  task automatic move(input logic [3:0] a, input logic [1:0] s);
    applyStimulus(a, s, 1'b1, 1'b0, 2'b00, 3'd0);
    waitIdle();
  endtask

  task automatic readCell(input logic [3:0] a, input logic [1:0] exp);
    rdAddr = a;
    tick();
    probe(0, int'(exp), $sformatf("rdCell%0d", a), 0);
  endtask

  task automatic pulseClear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Directed scenarios.
  initial begin
    reset = 1'b1; clear = 1'b0; we = 1'b0; addr = 4'd0; cellState = 2'b00; rdAddr = 4'd0;
    repeat (3) tick();
    probe(1, 0, "rstBusy", 0);
    probe(2, 0, "rstDone", 0);
    probe(3, 0, "rstWinner", 0);
    probe(4, 0, "rstWinLine", 0);
    probe(0, 0, "rstRdData", 0);
    probe(5, 0, "rstAck", 0);
    probe(6, 0, "rstErr", 0);
    tick();
    reset = 1'b0;
    tick();

    $display("[TB] X wins on the top row");
    move(4'd0, SX);
    move(4'd3, SO);
    move(4'd1, SX);
    move(4'd4, SO);
    applyStimulus(4'd2, SX, 1'b1, 1'b1, SX, 3'd0);
    probe(1, 1, "busyFirst", 0);
    probe(1, 1, "busyEighth", 7);
    probe(1, 0, "busyAfterScan", 8);
    probe(2, 0, "doneNotEarly", 7);
    probe(2, 1, "doneOnTime", 8);
    probe(3, int'(SX), "xWinner", 8);
    probe(4, 0, "xWinLine", 8);
    waitIdle();
    readCell(4'd0, SX);
    readCell(4'd2, SX);
    readCell(4'd3, SO);
    readCell(4'd5, 2'b00);
    readCell(4'd9, 2'b00);
    applyStimulus(4'd8, SO, 1'b0, 1'b0, 2'b00, 3'd0);
    readCell(4'd8, 2'b00);

    $display("[TB] clear while DONE");
    rdAddr = 4'd0;
    tick();
    probe(0, int'(SX), "rdBeforeClear", 0);
    pulseClear();
    probe(2, 0, "clearDone", 0);
    probe(3, 0, "clearWinner", 0);
    probe(4, 0, "clearWinLine", 0);
    probe(0, 0, "clearRdData", 0);
    for (int i = 0; i < 9; i++) begin
      readCell(i[3:0], 2'b00);
    end

    $display("[TB] rejected writes and diagonal O win");
    applyStimulus(4'd0, SX, 1'b1, 1'b0, 2'b00, 3'd0);
    applyStimulus(4'd5, SO, 1'b0, 1'b0, 2'b00, 3'd0);
    waitIdle();
    applyStimulus(4'd0, SO, 1'b0, 1'b0, 2'b00, 3'd0);
    applyStimulus(4'd9, SX, 1'b0, 1'b0, 2'b00, 3'd0);
    applyStimulus(4'd5, 2'b01, 1'b0, 1'b0, 2'b00, 3'd0);
    readCell(4'd5, 2'b00);
    readCell(4'd0, SX);
    move(4'd2, SO);
    move(4'd1, SX);
    move(4'd4, SO);
    move(4'd3, SX);
    applyStimulus(4'd6, SO, 1'b1, 1'b1, SO, 3'd7);
    waitIdle();
    probe(3, int'(SO), "oWinner", 0);
    probe(4, 7, "oWinLine", 0);
    tick();

    $display("[TB] clear together with write in IDLE");
    pulseClear();
    clear = 1'b1; we = 1'b1; addr = 4'd0; cellState = SX;
    tick();
    clear = 1'b0; we = 1'b0;
    probe(5, 0, "clearWeNoAck", 0);
    probe(6, 0, "clearWeNoErr", 0);
    tick();
    readCell(4'd0, 2'b00);
    probe(1, 0, "clearWeNoBusy", 0);

    $display("[TB] draw");
    move(4'd0, SX);
    move(4'd1, SO);
    move(4'd2, SX);
    move(4'd4, SO);
    move(4'd3, SX);
    move(4'd5, SO);
    move(4'd7, SX);
    move(4'd6, SO);
    applyStimulus(4'd8, SX, 1'b1, 1'b1, 2'b00, 3'd0);
    waitIdle();
    probe(2, 1, "drawDone", 0);
    probe(3, 0, "drawWinner", 0);
    tick();
    pulseClear();

    $display("[TB] reset during scan");
    applyStimulus(4'd4, SX, 1'b1, 1'b0, 2'b00, 3'd0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    probe(1, 0, "midRstBusy", 0);
    probe(2, 0, "midRstDone", 0);
    probe(3, 0, "midRstWinner", 0);
    tick();
    reset = 1'b0;
    readCell(4'd4, 2'b00);
    applyStimulus(4'd4, SX, 1'b1, 1'b0, 2'b00, 3'd0);
    waitIdle();
    probe(2, 0, "postRstIdle", 0);

    repeat (3) tick();
    checkOutput("respQDrained", respQ.size(), 0);
    checkOutput("doneQDrained", doneQ.size(), 0);
    checkOutput("probeQDrained", probeQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
